// File: rtl/link_stats_update_arbiter_pkg.sv
// Shared types and default geometry for the link-statistics histogram updater.
package link_stats_update_arbiter_pkg;
  localparam int DEF_N_SRC      = 5;
  localparam int DEF_SRC_BITS   = 3;
  localparam int DEF_CODE_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 48;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_ADDR_WIDTH = DEF_SRC_BITS + DEF_CODE_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } arbState_t;

  // Histogram bin address: source index in the upper bits, status code below.
  function automatic logic [DEF_ADDR_WIDTH-1:0] histAddr(
    input logic [DEF_SRC_BITS-1:0]   src,
    input logic [DEF_CODE_WIDTH-1:0] code
  );
    return {src, code};
  endfunction
endpackage

// File: rtl/link_stats_update_arbiter_if.sv
// Port-A bus of the histogram RAM; the arbiter is master, the RAM is slave.
interface link_stats_update_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 48
) ();
  logic [ADDR_W-1:0] ramAddr;
  logic              ramWen;
  logic [DATA_W-1:0] ramDin;
  logic [DATA_W-1:0] ramDout;

  modport master (output ramAddr, output ramWen, output ramDin, input ramDout);
  modport slave  (input ramAddr, input ramWen, input ramDin, output ramDout);
endinterface

// File: rtl/link_stats_event_fifo.sv
// Per-source event FIFO; a push on a full FIFO is accepted only when a pop frees a slot.
module link_stats_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             sysClk,
  input  logic             sysReset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wrPtr, rdPtr;
  logic             doPush, doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr[PW-1:0]];

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge sysClk) begin
    if (doPush) mem[wrPtr[PW-1:0]] <= din;
  end
endmodule

// File: rtl/link_stats_update_arbiter.sv
// Round-robin read-modify-write sequencer for the link-statistics histogram (RAM port A).
//   state | meaning
//   IDLE  | no work; grant a FIFO head or start a pending clear
//   READ  | bin address presented, waiting for registered read data
//   WRITE | write back saturating increment, optionally grant next event
//   CLEAR | zero one bin per cycle, address 0 up to all-ones
module link_stats_update_arbiter
  import link_stats_update_arbiter_pkg::*;
#(
  parameter int N_SRC      = DEF_N_SRC,
  parameter int SRC_BITS   = DEF_SRC_BITS,
  parameter int CODE_WIDTH = DEF_CODE_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic [N_SRC-1:0]            evStrobe,
  input  logic [N_SRC*CODE_WIDTH-1:0] evCode,
  input  logic                        clearReq,
  output logic                        clearBusy,
  output logic [N_SRC-1:0]            dropFlags,
  link_stats_update_arbiter_if.master ram
);
  localparam int ADDR_W = SRC_BITS + CODE_WIDTH;
  localparam logic [ADDR_W-1:0]   LAST_ADDR = '1;
  localparam logic [SRC_BITS-1:0] LAST_SRC  = SRC_BITS'(N_SRC - 1);

  arbState_t             state, stateNext;
  logic [SRC_BITS-1:0]   rrPtr, grantSrc, srcNext, startIdx, grantIdx;
  logic [ADDR_W-1:0]     addrReg;
  logic                  clearPending, grantNow, anyReady, enterClear, clearDone;
  logic [N_SRC-1:0]      fifoFull, fifoEmpty, popVec, newDrop, sweepDrops;
  logic [CODE_WIDTH-1:0] fifoHead [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : gFifo
    link_stats_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CODE_WIDTH)) uFifo (
      .sysClk  (sysClk),
      .sysReset(sysReset),
      .push    (evStrobe[i]),
      .pop     (popVec[i]),
      .din     (evCode[i*CODE_WIDTH +: CODE_WIDTH]),
      .dout    (fifoHead[i]),
      .full    (fifoFull[i]),
      .empty   (fifoEmpty[i])
    );
  end

  assign srcNext  = (grantSrc == LAST_SRC) ? '0 : grantSrc + 1'b1;
  // Back-to-back grants from WRITE search from the pointer value being written this cycle.
  assign startIdx = (state == WRITE) ? srcNext : rrPtr;
  assign anyReady = |(~fifoEmpty);

  always_comb begin
    grantIdx = startIdx;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      int idx;
      idx = int'(startIdx) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!fifoEmpty[idx]) grantIdx = SRC_BITS'(idx);
    end
  end

  always_comb begin
    stateNext = state;
    grantNow  = 1'b0;
    case (state)
      IDLE: begin
        if (clearPending) begin
          stateNext = CLEAR;
        end else if (anyReady) begin
          grantNow  = 1'b1;
          stateNext = READ;
        end
      end
      READ:  stateNext = WRITE;
      WRITE: begin
        if (clearPending) begin
          stateNext = CLEAR;
        end else if (anyReady) begin
          grantNow  = 1'b1;
          stateNext = READ;
        end else begin
          stateNext = IDLE;
        end
      end
      CLEAR: if (addrReg == LAST_ADDR) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    popVec = '0;
    if (grantNow) popVec[grantIdx] = 1'b1;
  end

  assign enterClear = (state != CLEAR) && (stateNext == CLEAR);
  assign clearDone  = (state == CLEAR) && (addrReg == LAST_ADDR);
  assign newDrop    = evStrobe & fifoFull & ~popVec;

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state        <= CLEAR;
      rrPtr        <= '0;
      grantSrc     <= '0;
      addrReg      <= '0;
      clearPending <= 1'b0;
      dropFlags    <= '0;
      sweepDrops   <= '0;
    end else begin
      state <= stateNext;
      if (enterClear)                        clearPending <= 1'b0;
      else if (clearReq && state != CLEAR)   clearPending <= 1'b1;
      if (state == WRITE) rrPtr <= srcNext;
      if (grantNow) begin
        grantSrc <= grantIdx;
        addrReg  <= histAddr(grantIdx, fifoHead[grantIdx]);
      end else if (enterClear) begin
        addrReg <= '0;
      end else if (state == CLEAR) begin
        addrReg <= addrReg + 1'b1;
      end
      // Drops that happen while the sweep runs must survive its completion.
      if (enterClear)          sweepDrops <= '0;
      else if (state == CLEAR) sweepDrops <= sweepDrops | newDrop;
      dropFlags <= clearDone ? (sweepDrops | newDrop) : (dropFlags | newDrop);
    end
  end

  assign clearBusy   = clearPending || (state == CLEAR);
  assign ram.ramAddr = addrReg;
  // Reset suppresses the write strobe so an abandoned RMW never lands in the RAM.
  assign ram.ramWen  = !sysReset && ((state == WRITE) || (state == CLEAR));
  assign ram.ramDin  = (sysReset || state != WRITE) ? '0 :
                       (&ram.ramDout) ? ram.ramDout : ram.ramDout + 1'b1;
endmodule

// File: tb/tb_link_stats_update_arbiter.sv
// Directed stimulus with a write scoreboard: expected RAM writes are queued, a monitor checks each ramWen.
module tb_link_stats_update_arbiter;
  logic       sysClk = 1'b0;
  logic       sysReset;
  logic [4:0] evStrobe;
  logic [9:0] evCode;
  logic       clearReq;
  logic       clearBusy;
  logic [4:0] dropFlags;
  logic       preEn;
  logic [4:0] preAddr;
  logic [47:0] preData;

  link_stats_update_arbiter_if #(.ADDR_W(5), .DATA_W(48)) ramBus ();

  link_stats_update_arbiter dut (
    .sysClk   (sysClk),
    .sysReset (sysReset),
    .evStrobe (evStrobe),
    .evCode   (evCode),
    .clearReq (clearReq),
    .clearBusy(clearBusy),
    .dropFlags(dropFlags),
    .ram      (ramBus)
  );

  always #5 sysClk = ~sysClk;

  logic [47:0] ramMem [32];
  always @(posedge sysClk) begin
    ramBus.ramDout <= ramMem[ramBus.ramAddr];
    if (preEn)              ramMem[preAddr] <= preData;
    else if (ramBus.ramWen) ramMem[ramBus.ramAddr] <= ramBus.ramDin;
  end

  typedef struct packed {
    logic [4:0]  addr;
    logic [47:0] data;
  } wr_t;
  wr_t expQ[$];
  int  total = 0;
  int  passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expectWr(input logic [4:0] a, input logic [47:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic expectSweep();
    for (int a = 0; a < 32; a++) expectWr(5'(a), 48'd0);
  endtask

  always @(negedge sysClk) begin
    if (ramBus.ramWen) begin
      if (expQ.size() == 0) begin
        total++;
        $display("FAIL wrUnexpected: write addr %0d data %0h with nothing expected",
                 ramBus.ramAddr, ramBus.ramDin);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        check("wrAddr", 64'(ramBus.ramAddr), 64'(e.addr));
        check("wrData", 64'(ramBus.ramDin), 64'(e.data));
      end
    end
  end

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge sysClk);
      n++;
    end
    check(name, 64'(expQ.size()), 64'd0);
  endtask

  task automatic waitClearDone(input string name);
    int n;
    n = 0;
    while (clearBusy && n < 100) begin
      @(negedge sysClk);
      n++;
    end
    check(name, 64'(clearBusy), 64'd0);
  endtask

  task automatic preload(input logic [4:0] a, input logic [47:0] d);
    @(posedge sysClk); #1;
    preEn = 1'b1; preAddr = a; preData = d;
    @(posedge sysClk); #1;
    preEn = 1'b0;
  endtask

  // Applies one strobe cycle; returns #1 after the edge that samples it.
  task automatic strobe(input logic [4:0] mask, input logic [9:0] codes);
    @(posedge sysClk); #1;
    evStrobe = mask; evCode = codes;
    @(posedge sysClk); #1;
    evStrobe = '0; evCode = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wr;
    sysReset = 1'b1; evStrobe = '0; evCode = '0; clearReq = 1'b0;
    preEn = 1'b0; preAddr = '0; preData = '0;

    // Reset values and post-reset sweep
    @(posedge sysClk);
    @(negedge sysClk);
    check("rstRamWen", 64'(ramBus.ramWen), 64'd0);
    check("rstRamAddr", 64'(ramBus.ramAddr), 64'd0);
    check("rstRamDin", 64'(ramBus.ramDin), 64'd0);
    check("rstDropFlags", 64'(dropFlags), 64'd0);
    check("rstClearBusy", 64'(clearBusy), 64'd1);
    expectSweep();
    @(posedge sysClk); #1;
    sysReset = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge sysClk);
      if (clearBusy) n++;
      else break;
    end
    check("sweepBusyCycles", 64'(n), 64'd32);
    waitDrain("sweepDrain");

    // Simultaneous strobes: src0..4 codes 0,1,2,3,1 -> bins 0,5,10,15,17
    expectWr(5'd0, 48'd1);
    expectWr(5'd5, 48'd1);
    expectWr(5'd10, 48'd1);
    expectWr(5'd15, 48'd1);
    expectWr(5'd17, 48'd1);
    strobe(5'b11111, 10'b01_11_10_01_00);
    n = 0; wr = 0;
    while (wr < 5 && n < 40) begin
      @(negedge sysClk);
      n++;
      if (ramBus.ramWen) wr++;
    end
    check("burstSpan", 64'(n), 64'd11);
    waitDrain("burst1Drain");

    // Pointer wrapped to 0: src0 code3 (bin 3) before src4 code2 (bin 18)
    expectWr(5'd3, 48'd1);
    expectWr(5'd18, 48'd1);
    strobe(5'b10001, 10'b10_00_00_00_11);
    waitDrain("burst2Drain");

    // Single event: src1 code2 -> bin 6 holding 7
    preload(5'd6, 48'd7);
    expectWr(5'd6, 48'd8);
    strobe(5'b00010, 10'b00_00_00_10_00);
    n = 0;
    do begin
      @(negedge sysClk);
      n++;
    end while (!ramBus.ramWen && n < 10);
    check("evLatency", 64'(n), 64'd3);
    waitDrain("singleDrain");

    // Saturation: src3 code1 -> bin 13 holding all-ones
    preload(5'd13, 48'hFFFF_FFFF_FFFF);
    expectWr(5'd13, 48'hFFFF_FFFF_FFFF);
    strobe(5'b01000, 10'b00_01_00_00_00);
    waitDrain("satDrain");

    // Overflow: 6 strobes on src3 code2 during a sweep -> 4 increments of bin 14
    expectSweep();
    for (int v = 1; v <= 4; v++) expectWr(5'd14, 48'(v));
    @(posedge sysClk); #1;
    clearReq = 1'b1;
    @(posedge sysClk); #1;
    clearReq = 1'b0;
    @(negedge sysClk);
    check("clrBusyRise", 64'(clearBusy), 64'd1);
    @(posedge sysClk); #1;
    evStrobe = 5'b01000; evCode = 10'b00_10_00_00_00;
    repeat (6) @(posedge sysClk);
    #1;
    evStrobe = '0; evCode = '0;
    @(negedge sysClk);
    check("dropMidSweep", 64'(dropFlags), 64'h08);
    waitClearDone("ovfClearDone");
    check("dropAfterSweep", 64'(dropFlags), 64'h08);
    waitDrain("ovfDrain");
    check("dropAfterDrain", 64'(dropFlags), 64'h08);

    // Clear requested in READ: WRITE of bin 8 completes, then one sweep only
    expectWr(5'd8, 48'd1);
    expectSweep();
    @(posedge sysClk); #1;
    evStrobe = 5'b00100; evCode = '0;
    @(posedge sysClk); #1;
    evStrobe = '0;
    @(posedge sysClk); #1;
    clearReq = 1'b1;
    @(posedge sysClk); #1;
    clearReq = 1'b0;
    @(negedge sysClk);
    check("rmwWriteWen", 64'(ramBus.ramWen), 64'd1);
    check("rmwWriteBusy", 64'(clearBusy), 64'd1);
    repeat (10) @(posedge sysClk);
    #1;
    clearReq = 1'b1;
    @(posedge sysClk); #1;
    clearReq = 1'b0;
    @(negedge sysClk);
    check("dropUntilNextClear", 64'(dropFlags), 64'h08);
    waitClearDone("rmwClearDone");
    check("dropCleared", 64'(dropFlags), 64'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge sysClk);
      if (clearBusy) n++;
    end
    check("noSecondSweep", 64'(n), 64'd0);
    waitDrain("finalDrain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
